// File: rtl/spi_shift_pkg.sv
// Shared definitions for the parametrised SPI shift engine:
// default geometry, width helpers and the SCLK edge-select encoding.
package spi_shift_pkg;

  localparam int unsigned SPI_MAX_CHAR_DEF = 128;
  localparam int unsigned SPI_BUS_W_DEF    = 32;

  typedef enum logic {
    EDGE_POS = 1'b0,
    EDGE_NEG = 1'b1
  } edge_sel_e;

  // Ceiling log2, usable in parameter expressions.
  function automatic int unsigned clog2_f(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Word-index width, never narrower than one bit.
  function automatic int unsigned wsel_w_f(input int unsigned max_char,
                                           input int unsigned bus_w);
    int unsigned w;
    w = clog2_f(max_char / bus_w);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/spi_char_counter.sv
// Character bit counter and transfer sequencing for the SPI shift engine.
// Ports:
//   wb_clk, wb_rst  clock, async active-high reset
//   go_i            start request (ignored while busy)
//   pos_edge_i      SCLK leading-edge strobe
//   n_len_i         effective character length (1..MAX_CHAR)
//   cnt_o           remaining-bit counter
//   tip_o           transfer in progress
//   last_o          counter is zero
//   done_o          one-cycle end-of-transfer pulse
module spi_char_counter #(
  parameter int unsigned CLEN_W = 7
) (
  input  logic            wb_clk,
  input  logic            wb_rst,
  input  logic            go_i,
  input  logic            pos_edge_i,
  input  logic [CLEN_W:0] n_len_i,
  output logic [CLEN_W:0] cnt_o,
  output logic            tip_o,
  output logic            last_o,
  output logic            done_o
);

  localparam int unsigned CNT_W = CLEN_W + 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               last_q, last_d;
  logic               done_q, done_d;

  // State register; counter resets to zero so last reads high.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  // Next-state: idle preloads the length; busy counts leading edges and
  // ends on the leading edge seen after the counter reached zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = n_len_i;
        if (go_i) state_d = ST_BUSY;
      end
      ST_BUSY: begin
        if (pos_edge_i) begin
          if (cnt_q == '0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    last_d = (cnt_d == '0);
  end

  assign cnt_o  = cnt_q;
  assign tip_o  = (state_q == ST_BUSY);
  assign last_o = last_q;
  assign done_o = done_q;

endmodule

// File: rtl/spi_shiftreg_param.sv
// Parametrised SPI shift engine: shifts a programmable-length character out
// on mosi and in from miso under SCLK edge strobes, with word-indexed host
// access to the shift data.
// Optional build macro: SPI_SHIFT_LOOPBACK_EN adds input 'loopback', which
// makes the receive side sample the mosi register instead of miso.
// Ports:
//   wb_clk, wb_rst           clock, async active-high reset
//   pos_edge, neg_edge       SCLK leading/trailing edge strobes
//   rx_negedge, tx_negedge   sample/drive on trailing edge when set
//   lsb                      LSB-first order
//   go                       start request
//   miso                     serial in
//   len                      char length (0 = MAX_CHAR)
//   wr_en, rd_en, wsel       host write/read of word wsel
//   byte_sel, pin            byte enables, write data
//   mosi                     serial out
//   tip, last, done          in progress, counter zero, end pulse
//   wr_err                   sticky access-while-busy flag
//   pout                     read data
module spi_shiftreg_param
  import spi_shift_pkg::*;
#(
  parameter int unsigned MAX_CHAR = SPI_MAX_CHAR_DEF,
  parameter int unsigned BUS_W    = SPI_BUS_W_DEF,
  parameter int unsigned CLEN_W   = clog2_f(MAX_CHAR),
  parameter int unsigned WSEL_W   = wsel_w_f(MAX_CHAR, BUS_W)
) (
  input  logic               wb_clk,
  input  logic               wb_rst,
  input  logic               pos_edge,
  input  logic               neg_edge,
  input  logic               rx_negedge,
  input  logic               tx_negedge,
  input  logic               lsb,
  input  logic               go,
  input  logic               miso,
`ifdef SPI_SHIFT_LOOPBACK_EN
  input  logic               loopback,
`endif
  input  logic [CLEN_W-1:0]  len,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [WSEL_W-1:0]  wsel,
  input  logic [BUS_W/8-1:0] byte_sel,
  input  logic [BUS_W-1:0]   pin,
  output logic               mosi,
  output logic               tip,
  output logic               last,
  output logic               done,
  output logic               wr_err,
  output logic [BUS_W-1:0]   pout
);

  localparam int unsigned NBYTES = BUS_W / 8;
  localparam int unsigned CNT_W  = CLEN_W + 1;
  localparam int unsigned BIDX_W = clog2_f(BUS_W);

  logic [CNT_W-1:0]    n_len_c;
  logic [CNT_W-1:0]    cnt;
  logic [CLEN_W-1:0]   pos_c;
  logic [CLEN_W-1:0]   word_base_c;
  logic                shift_ok_c;
  logic                tx_clk_c;
  logic                rx_clk_c;
  logic                rx_bit_c;
  edge_sel_e           tx_mode_c;
  edge_sel_e           rx_mode_c;

  logic [MAX_CHAR-1:0] data_q, data_d;
  logic [BUS_W-1:0]    pout_q, pout_d;
  logic                mosi_q, mosi_d;
  logic                wr_err_q, wr_err_d;

  assign n_len_c = (len == '0) ? CNT_W'(MAX_CHAR) : {1'b0, len};

  spi_char_counter #(
    .CLEN_W (CLEN_W)
  ) u_cnt (
    .wb_clk     (wb_clk),
    .wb_rst     (wb_rst),
    .go_i       (go),
    .pos_edge_i (pos_edge),
    .n_len_i    (n_len_c),
    .cnt_o      (cnt),
    .tip_o      (tip),
    .last_o     (last),
    .done_o     (done)
  );

  assign tx_mode_c  = edge_sel_e'(tx_negedge);
  assign rx_mode_c  = edge_sel_e'(rx_negedge);
  assign tx_clk_c   = tip && ((tx_mode_c == EDGE_NEG) ? neg_edge : pos_edge);
  assign rx_clk_c   = tip && ((rx_mode_c == EDGE_NEG) ? neg_edge : pos_edge);
  assign shift_ok_c = (cnt != '0);

  // Bit under the shifter: ascends from 0 for LSB-first, descends from N-1 otherwise.
  assign pos_c = lsb ? CLEN_W'(n_len_c - cnt) : CLEN_W'(cnt - CNT_W'(1));

  assign word_base_c = CLEN_W'(32'(wsel) * BUS_W);

`ifdef SPI_SHIFT_LOOPBACK_EN
  assign rx_bit_c = loopback ? mosi_q : miso;
`else
  assign rx_bit_c = miso;
`endif

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      data_q   <= '0;
      pout_q   <= '0;
      mosi_q   <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      data_q   <= data_d;
      pout_q   <= pout_d;
      mosi_q   <= mosi_d;
      wr_err_q <= wr_err_d;
    end
  end

  // Shift and host-access next state; host reads see pre-write data.
  always_comb begin
    data_d   = data_q;
    pout_d   = pout_q;
    mosi_d   = mosi_q;
    wr_err_d = wr_err_q;
    if (tx_clk_c && shift_ok_c) mosi_d = data_q[pos_c];
    if (rx_clk_c && shift_ok_c) data_d[pos_c] = rx_bit_c;
    if (tip) begin
      if (wr_en || rd_en) wr_err_d = 1'b1;
    end else begin
      for (int b = 0; b < int'(NBYTES); b++) begin
        if (byte_sel[b]) begin
          if (rd_en) pout_d[BIDX_W'(8 * b) +: 8] = data_q[word_base_c + CLEN_W'(8 * b) +: 8];
          if (wr_en) data_d[word_base_c + CLEN_W'(8 * b) +: 8] = pin[BIDX_W'(8 * b) +: 8];
        end
      end
      // An empty write to word 0 is the clear command for the error flag.
      if (wr_en && (wsel == '0) && (byte_sel == '0)) wr_err_d = 1'b0;
    end
  end

  assign mosi   = mosi_q;
  assign wr_err = wr_err_q;
  assign pout   = pout_q;

endmodule

// File: tb/tb_spi_shiftreg_param.sv
// Randomised self-checking bench for spi_shiftreg_param (default geometry
// 128-bit character, 32-bit bus) against a transfer-level reference model.
module tb_spi_shiftreg_param;

  logic        wb_clk = 1'b0;
  logic        wb_rst;
  logic        pos_edge, neg_edge, rx_negedge, tx_negedge, lsb, go, miso;
  logic [6:0]  len;
  logic        wr_en, rd_en;
  logic [1:0]  wsel;
  logic [3:0]  byte_sel;
  logic [31:0] pin;
  logic        mosi, tip, last, done, wr_err;
  logic [31:0] pout;
`ifdef SPI_SHIFT_LOOPBACK_EN
  logic        loopback;
`endif

  int n_chk;
  int n_bad;

  logic [127:0] mdl_data;
  logic [31:0]  mdl_pout;
  logic         mdl_wr_err;
  logic         mdl_mosi;
  logic [127:0] obs_seq;
  int           tip_cnt;

  always #5 wb_clk = ~wb_clk;

  spi_shiftreg_param dut (
    .wb_clk     (wb_clk),
    .wb_rst     (wb_rst),
    .pos_edge   (pos_edge),
    .neg_edge   (neg_edge),
    .rx_negedge (rx_negedge),
    .tx_negedge (tx_negedge),
    .lsb        (lsb),
    .go         (go),
    .miso       (miso),
`ifdef SPI_SHIFT_LOOPBACK_EN
    .loopback   (loopback),
`endif
    .len        (len),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .wsel       (wsel),
    .byte_sel   (byte_sel),
    .pin        (pin),
    .mosi       (mosi),
    .tip        (tip),
    .last       (last),
    .done       (done),
    .wr_err     (wr_err),
    .pout       (pout)
  );

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic idle_host();
    wr_en = 1'b0; rd_en = 1'b0; wsel = '0; byte_sel = '0; pin = '0;
  endtask

  // One idle-time host access; reads capture the pre-write contents.
  task automatic host_acc(input bit we, input bit re, input int w,
                          input logic [3:0] bs, input logic [31:0] d);
    wr_en = we; rd_en = re; wsel = 2'(w); byte_sel = bs; pin = d;
    for (int b = 0; b < 4; b++) begin
      if (bs[b] && re) mdl_pout[8*b +: 8] = mdl_data[w*32 + 8*b +: 8];
    end
    for (int b = 0; b < 4; b++) begin
      if (bs[b] && we) mdl_data[w*32 + 8*b +: 8] = d[8*b +: 8];
    end
    if (we && w == 0 && bs == 4'h0) mdl_wr_err = 1'b0;
    step();
    idle_host();
    if (re) check_val("pout", 128'(pout), 128'(mdl_pout));
    check_val("wr_err", 128'(wr_err), 128'(mdl_wr_err));
  endtask

  task automatic read_all();
    for (int w = 0; w < 4; w++) host_acc(1'b0, 1'b1, w, 4'hF, 32'h0);
  endtask

  // Whole transfer: the model walks the character in shift order; the drive
  // loop issues neg_edge then pos_edge per SCLK period.
  task automatic run_xfer(input int ln, input bit lsb_v, input bit txn, input bit rxn,
                          input bit lb, input logic [127:0] mbits, input bit busy_acc,
                          input bit go_wr, input logic [31:0] go_pin);
    int           n;
    int           pidx;
    logic         old_m;
    logic         rv;
    logic [127:0] exp_m;
    n = (ln == 0) ? 128 : ln;
    if (go_wr) mdl_data[7:0] = go_pin[7:0];
    exp_m = '0;
    for (int k = 0; k < n; k++) begin
      pidx  = lsb_v ? k : (n - 1 - k);
      old_m = mdl_mosi;
      if (rxn && !txn) begin
        rv = lb ? old_m : mbits[k];
        mdl_data[pidx] = rv;
        mdl_mosi = rv;
      end else if (txn && !rxn) begin
        mdl_mosi = mdl_data[pidx];
        mdl_data[pidx] = lb ? mdl_mosi : mbits[k];
      end else begin
        mdl_mosi = mdl_data[pidx];
        mdl_data[pidx] = lb ? old_m : mbits[k];
      end
      exp_m[k] = mdl_mosi;
    end
    if (busy_acc) mdl_wr_err = 1'b1;

    len = 7'(ln); lsb = lsb_v; tx_negedge = txn; rx_negedge = rxn;
`ifdef SPI_SHIFT_LOOPBACK_EN
    loopback = lb;
`endif
    go = 1'b1;
    if (go_wr) begin
      wr_en = 1'b1; wsel = 2'd0; byte_sel = 4'b0001; pin = go_pin;
    end
    step();
    go = 1'b0;
    idle_host();
    check_val("tip_rise", 128'(tip), 128'd1);
    obs_seq = '0;
    tip_cnt = 0;
    for (int p = 0; p <= n; p++) begin
      miso = (p < n) ? mbits[p] : 1'b0;
      neg_edge = 1'b1;
      if (busy_acc && p == 1) begin
        wr_en = 1'b1; wsel = 2'd0; byte_sel = 4'hF; pin = 32'hFFFF_FFFF;
      end
      if (busy_acc && p == 2) begin
        rd_en = 1'b1; wsel = 2'd0; byte_sel = 4'hF;
      end
      step();
      neg_edge = 1'b0;
      idle_host();
      if (txn && p < n) begin
        obs_seq[p] = mosi;
        check_val("mosi_neg", 128'(mosi), 128'(exp_m[p]));
      end
      if (tip) tip_cnt++;
      pos_edge = 1'b1;
      step();
      pos_edge = 1'b0;
      if (!txn && p < n) begin
        obs_seq[p] = mosi;
        check_val("mosi_pos", 128'(mosi), 128'(exp_m[p]));
      end
      if (p < n) begin
        check_val("tip_hold", 128'(tip), 128'd1);
        check_val("done_low", 128'(done), 128'd0);
        check_val("last", 128'(last), 128'(p == n - 1));
      end
    end
    check_val("tip_fall", 128'(tip), 128'd0);
    check_val("done_pulse", 128'(done), 128'd1);
    check_val("mosi_hold", 128'(mosi), 128'(mdl_mosi));
    step();
    check_val("done_once", 128'(done), 128'd0);
    if (busy_acc) check_val("busy_err", 128'(wr_err), 128'd1);
  endtask

  initial begin
    logic [127:0] mb;
    logic [7:0]   c3;
    bit           lbv;

    n_chk = 0; n_bad = 0;
    wb_rst = 1'b1;
    pos_edge = 1'b0; neg_edge = 1'b0; rx_negedge = 1'b0; tx_negedge = 1'b0;
    lsb = 1'b0; go = 1'b0; miso = 1'b0; len = '0;
`ifdef SPI_SHIFT_LOOPBACK_EN
    loopback = 1'b0;
`endif
    idle_host();
    mdl_data = '0; mdl_pout = '0; mdl_wr_err = 1'b0; mdl_mosi = 1'b0;

    repeat (3) @(posedge wb_clk);
    #1;
    check_val("rst_mosi", 128'(mosi), 128'd0);
    check_val("rst_tip", 128'(tip), 128'd0);
    check_val("rst_done", 128'(done), 128'd0);
    check_val("rst_err", 128'(wr_err), 128'd0);
    check_val("rst_pout", 128'(pout), 128'd0);
    check_val("rst_last", 128'(last), 128'd1);
    wb_rst = 1'b0;
    step();

    // MSB-first 8-bit character, trailing-edge drive, leading-edge sample
    host_acc(1'b1, 1'b0, 0, 4'b0001, 32'h0000_00A5);
    c3 = 8'hC3;
    mb = '0;
    for (int k = 0; k < 8; k++) mb[k] = c3[7-k];
    run_xfer(8, 1'b0, 1'b1, 1'b0, 1'b0, mb, 1'b0, 1'b0, 32'h0);
    check_val("msb_seq", 128'(obs_seq[7:0]), 128'h0A5);
    host_acc(1'b0, 1'b1, 0, 4'b0001, 32'h0);
    check_val("msb_rx", 128'(pout[7:0]), 128'h0C3);

    // Access while busy: data untouched, sticky error, then clear
    for (int w = 0; w < 4; w++) host_acc(1'b1, 1'b0, w, 4'hF, $urandom);
    mb = {$urandom, $urandom, $urandom, $urandom};
    run_xfer(16, 1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0, mb, 1'b1, 1'b0, 32'h0);
    read_all();
    host_acc(1'b1, 1'b0, 0, 4'h0, 32'hFFFF_FFFF);
    check_val("err_clear", 128'(wr_err), 128'd0);

    // Full-depth LSB-first transfer; the top bit is shifted last
    host_acc(1'b1, 1'b0, 3, 4'hF, 32'h8000_0000);
    mb = {$urandom, $urandom, $urandom, $urandom};
    run_xfer(0, 1'b1, 1'b1, 1'b0, 1'b0, mb, 1'b0, 1'b0, 32'h0);
    check_val("lsb_last", 128'(obs_seq[127]), 128'd1);
    check_val("lsb_tip", 128'(tip_cnt), 128'd129);
    read_all();

    // Write landing on the same edge as go
    host_acc(1'b1, 1'b0, 0, 4'hF, 32'h0);
    run_xfer(1, 1'b1, 1'b1, 1'b0, 1'b0, 128'h0, 1'b0, 1'b1, 32'h0000_0001);
    check_val("gowr_bit", 128'(obs_seq[0]), 128'd1);

    // Simultaneous write and read of one word returns the old value
    host_acc(1'b1, 1'b1, 1, 4'hF, $urandom);
    host_acc(1'b0, 1'b1, 1, 4'hF, 32'h0);

    // Randomised transfers over all edge/order combinations
    for (int it = 0; it < 16; it++) begin
      for (int w = 0; w < 4; w++) host_acc(1'b1, 1'b0, w, 4'($urandom_range(0, 15)), $urandom);
      mb = {$urandom, $urandom, $urandom, $urandom};
`ifdef SPI_SHIFT_LOOPBACK_EN
      lbv = 1'($urandom_range(0, 1));
`else
      lbv = 1'b0;
`endif
      run_xfer(int'($urandom_range(0, 127)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), lbv, mb, 1'b0, 1'b0, 32'h0);
      host_acc(1'b0, 1'b1, int'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 32'h0);
      read_all();
    end

`ifdef SPI_SHIFT_LOOPBACK_EN
    // Loopback keeps the character intact with miso held low
    host_acc(1'b1, 1'b0, 0, 4'b0001, 32'h0000_005A);
    run_xfer(8, 1'b0, 1'b1, 1'b0, 1'b1, 128'h0, 1'b0, 1'b0, 32'h0);
    host_acc(1'b0, 1'b1, 0, 4'b0001, 32'h0);
    check_val("lb_pout", 128'(pout[7:0]), 128'h05A);
    loopback = 1'b0;
`endif

    // Reset part-way through a transfer (counter at 4)
    for (int w = 0; w < 4; w++) host_acc(1'b1, 1'b0, w, 4'hF, $urandom | 32'h1);
    len = 7'd16; lsb = 1'b0; tx_negedge = 1'b1; rx_negedge = 1'b0; miso = 1'b1;
    go = 1'b1;
    step();
    go = 1'b0;
    for (int p = 0; p < 12; p++) begin
      neg_edge = 1'b1; step(); neg_edge = 1'b0;
      pos_edge = 1'b1; step(); pos_edge = 1'b0;
    end
    check_val("mid_tip", 128'(tip), 128'd1);
    #2 wb_rst = 1'b1;
    #1;
    check_val("mid_rst_tip", 128'(tip), 128'd0);
    check_val("mid_rst_mosi", 128'(mosi), 128'd0);
    check_val("mid_rst_last", 128'(last), 128'd1);
    check_val("mid_rst_done", 128'(done), 128'd0);
    mdl_data = '0; mdl_pout = '0; mdl_wr_err = 1'b0; mdl_mosi = 1'b0;
    step();
    wb_rst = 1'b0;
    step();
    check_val("mid_no_done", 128'(done), 128'd0);
    step();
    check_val("mid_no_done2", 128'(done), 128'd0);
    read_all();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
